spi_master_rw: RTL and testbench
================================

Name: spi_master_rw

Overview:
Parametrised successor to the team's write-only SPI sender, for configuring external converters and PLLs from the control FSMs.
- All four SPI modes, selected per transaction.
- Read and write transactions, with a serial data-in pin.
- Runtime-programmable SCLK divider.
- N_CS active-low chip selects.
Sits between the internal configuration sequencer (start/done handshake) and the board-level serial pins.

Parameters:
DATA_BITS, 16, data field width (>=1)
ADDR_BITS, 8, address field width (>=1)
N_CS, 2, number of chip-select outputs (>=1)
DIV_BITS, 8, width of the divider input

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  transaction request; sampled only in IDLE
rw  input  1  1 = read, 0 = write
mode  input  2  {CPOL,CPHA}; latched at accept
cs_sel  input  $clog2(N_CS) or 1  chip-select index
address  input  ADDR_BITS  register address
wdata  input  DATA_BITS  write data
div  input  DIV_BITS  SCLK half-period in clk cycles; 0 is treated as 1
done_o  output  1  one-cycle pulse at end of frame
busy  output  1  high from accept until done_o
rdata  output  DATA_BITS  captured read data; holds until the next read completes
SEN  output  N_CS  serial enables, active low
SCLK  output  1  serial clock
SDATA  output  1  serial data out (MOSI)
SDOUT  input  1  serial data in (MISO)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset values: SEN all 1; SCLK 0; SDATA 1; done_o 0; busy 0; rdata 0; state IDLE. Reset mid-frame aborts immediately with no done_o.
- Frame: {rw, address, wdata} shifted MSB-first, FRAME = 1+ADDR_BITS+DATA_BITS bits. On a read, SDATA drives 0 during the data field.
- States and transitions:
  - IDLE: SCLK follows mode[1] each cycle; SDATA=1.
  - IDLE -> LEAD when start=1 and cs_sel<N_CS. At accept: latch rw, mode, cs_sel, address, wdata and H=max(div,1); set busy=1.
  - start with cs_sel>=N_CS is ignored: no SEN, no done_o, busy stays 0.
  - LEAD (H cycles): SEN[cs_sel]=0. For CPHA=0, SDATA carries bit FRAME-1 from the first LEAD cycle.
  - SHIFT (2*H*FRAME cycles): SCLK toggles every H cycles, starting from CPOL. Leading edge = first toggle of each bit; trailing edge = second.
    - CPHA=0: SDOUT sampled on the leading edge; next SDATA bit driven on the trailing edge.
    - CPHA=1: SDATA driven on the leading edge; SDOUT sampled on the trailing edge.
  - TRAIL (H cycles): SCLK at CPOL; SDATA held.
  - TRAIL -> IDLE: SEN all 1, SDATA=1, done_o=1 for exactly one cycle, busy=0. On a read, rdata is updated in that same cycle from the last DATA_BITS sampled bits.
- Timing: SEN low for exactly 2*H*(FRAME+1) cycles. Accept cycle to done_o = 2*H*(FRAME+1)+1 cycles.
- Back-to-back: start is accepted in the cycle after done_o; SEN is high for at least 1 cycle between frames.
- start while busy is ignored. Inputs other than SDOUT may change after accept without effect.
- Bit counter: $clog2(FRAME+1) bits. Divider counter: DIV_BITS bits. No wrap-around within a frame.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit), latched at accept. When it is 1, each field (address, data) shifts LSB-first; the rw bit is still sent first, and rdata is assembled LSB-first.
- Undefined: the port is absent and all fields are MSB-first.

Test Plan:
1. Mode 0 write, div=2, cs_sel=1, address=0xA5, wdata=0x1234 -> SEN[1] low 104 cycles, SEN[0] stays 1. Bits sampled on SCLK rising: 0,10100101,0001001000110100. One done_o; rdata stays 0.
2. Mode 3 read, div=3, address=0x3C, slave model returns 0xBEEF -> SCLK idles 1, SDATA is 0 for 16 data bits, rdata=0xBEEF in the done_o cycle, SEN low 156 cycles.
3. Modes 1 and 2 write, wdata=0x8001, div=0 -> H=1, SCLK period 2 clk. Slave model sampling on the correct edge per CPHA receives 0x8001.
4. reset_n low at cycle 40 of a frame -> SEN=all 1, SCLK=0, SDATA=1, busy=0 asynchronously; no done_o. The next start is accepted normally.
5. start held high continuously, cs_sel=0, 3 frames -> exactly 3 done_o pulses, SEN high exactly 1 cycle between frames. start pulses during busy are ignored.
6. cs_sel=2 with N_CS=2 -> no SEN assertion, busy=0, no done_o. With SPI_LSB_FIRST_EN, lsb_first=1, address=0x01 -> rw then address bits 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/spi_master_rw.sv
// spi_master_rw: SPI master with per-transaction mode, read/write frames, runtime SCLK divider and N_CS selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first port (address and data fields shifted LSB-first).
module spi_master_rw #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 8,
  parameter int N_CS      = 2,
  parameter int DIV_BITS  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  input  logic                                     rw,
  input  logic [1:0]                               mode,
  input  logic [(N_CS > 1 ? $clog2(N_CS) : 1)-1:0] cs_sel,
  input  logic [ADDR_BITS-1:0]                     address,
  input  logic [DATA_BITS-1:0]                     wdata,
  input  logic [DIV_BITS-1:0]                      div,
`ifdef SPI_LSB_FIRST_EN
  input  logic                                     lsb_first,
`endif
  output logic                                     done_o,
  output logic                                     busy,
  output logic [DATA_BITS-1:0]                     rdata,
  output logic [N_CS-1:0]                          SEN,
  output logic                                     SCLK,
  output logic                                     SDATA,
  input  logic                                     SDOUT
);
  localparam int FRAME = 1 + ADDR_BITS + DATA_BITS;
  localparam int BW = $clog2(FRAME + 1);
  localparam logic [1:0] IDLE = 2'd0, LEAD = 2'd1, SHIFT = 2'd2, TRAIL = 2'd3;

  logic [1:0]           r_state;
  logic [DIV_BITS-1:0]  r_h, r_cnt;
  logic [BW-1:0]        r_bit;
  logic                 r_half, r_rw, r_cpha;
  logic [FRAME-1:0]     r_shift;
  logic [DATA_BITS-1:0] r_rx;
  logic [DIV_BITS-1:0]  w_h;
  logic                 w_tick, w_last, w_cs_ok;
  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_wd, w_rd;
  logic [FRAME-1:0]     w_frame;

  assign w_h     = (div == '0) ? DIV_BITS'(1) : div;
  assign w_tick  = r_cnt == '0;
  assign w_last  = r_bit == BW'(FRAME - 1);
  assign w_cs_ok = 32'(cs_sel) < N_CS;
`ifdef SPI_LSB_FIRST_EN
  logic                 r_lsb;
  logic [ADDR_BITS-1:0] w_addr_rev;
  logic [DATA_BITS-1:0] w_wdata_rev, w_rx_rev;
  assign w_addr_rev  = {<<{address}};
  assign w_wdata_rev = {<<{wdata}};
  assign w_rx_rev    = {<<{r_rx}};
  assign w_addr      = lsb_first ? w_addr_rev : address;
  assign w_wd        = rw ? '0 : (lsb_first ? w_wdata_rev : wdata);
  assign w_rd        = r_lsb ? w_rx_rev : r_rx;
`else
  assign w_addr      = address;
  assign w_wd        = rw ? '0 : wdata;
  assign w_rd        = r_rx;
`endif
  assign w_frame = {rw, w_addr, w_wd};

  // r_half: 0 = next SHIFT tick is the leading edge of the bit, 1 = trailing edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      SEN     <= '1;
      SCLK    <= 1'b0;
      SDATA   <= 1'b1;
      done_o  <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
      r_h     <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_half  <= 1'b0;
      r_rw    <= 1'b0;
      r_cpha  <= 1'b0;
      r_shift <= '0;
      r_rx    <= '0;
`ifdef SPI_LSB_FIRST_EN
      r_lsb   <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          SCLK  <= mode[1];
          SDATA <= 1'b1;
          if (start && w_cs_ok) begin
            r_state <= LEAD;
            busy    <= 1'b1;
            r_rw    <= rw;
            r_cpha  <= mode[0];
            r_h     <= w_h;
            r_cnt   <= w_h - DIV_BITS'(1);
            r_shift <= w_frame;
            SDATA   <= rw;
            SEN     <= ~(N_CS'(1) << cs_sel);
`ifdef SPI_LSB_FIRST_EN
            r_lsb   <= lsb_first;
`endif
          end
        end
        LEAD: begin
          r_cnt <= w_tick ? r_h - DIV_BITS'(1) : r_cnt - DIV_BITS'(1);
          if (w_tick) begin
            r_state <= SHIFT;
            r_bit   <= '0;
            r_half  <= 1'b0;
          end
        end
        SHIFT: begin
          r_cnt <= w_tick ? r_h - DIV_BITS'(1) : r_cnt - DIV_BITS'(1);
          if (w_tick) begin
            SCLK   <= ~SCLK;
            r_half <= ~r_half;
            if (r_half == r_cpha) r_rx <= DATA_BITS'({r_rx, SDOUT});
            if (!r_half && r_cpha) begin
              SDATA   <= r_shift[FRAME-1];
              r_shift <= r_shift << 1;
            end
            if (r_half && !r_cpha && !w_last) begin
              SDATA   <= r_shift[FRAME-2];
              r_shift <= r_shift << 1;
            end
            if (r_half) r_bit <= r_bit + BW'(1);
            if (r_half && w_last) r_state <= TRAIL;
          end
        end
        TRAIL: begin
          r_cnt <= r_cnt - DIV_BITS'(1);
          if (w_tick) begin
            r_state <= IDLE;
            SEN     <= '1;
            SDATA   <= 1'b1;
            done_o  <= 1'b1;
            busy    <= 1'b0;
            if (r_rw) rdata <= w_rd;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_spi_master_rw.sv
// tb_spi_master_rw: directed vector bench for spi_master_rw with an edge-tracking SPI slave model.
module tb_spi_master_rw;
  localparam int FRAME = 25;

  typedef struct {
    logic        rw;
    logic [1:0]  mode;
    logic        cs;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  div;
    logic [15:0] resp;
    logic        lsb;
    logic [24:0] cap;
    int          sen_len;
    logic [1:0]  sen;
    logic [15:0] rdata;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, rw = 1'b0, SDOUT = 1'b0;
  logic [1:0] mode = '0;
  logic cs_sel = 1'b0;
  logic [7:0] address = '0, div = '0;
  logic [15:0] wdata = '0;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first = 1'b0;
`endif
  logic done_o, busy, SCLK, SDATA;
  logic [15:0] rdata;
  logic [1:0] SEN;
  logic start2 = 1'b0;
  logic [1:0] cs2 = '0;
  logic done2, busy2, SCLK2, SDATA2;
  logic [15:0] rdata2;
  logic [2:0] SEN2;

  int checks = 0, errors = 0;
  logic [FRAME-1:0] miso_vec = '0, cap = '0;
  int ncap = 0, edges = 0, mi = 0, sen_cnt = 0, sen_len = 0, hi_cnt = 0, gap1 = 0, done_cnt = 0;
  logic [1:0] sen_frame = '1;
  logic prev_sclk = 1'b0, prev_low = 1'b0, low_now, tb_cpha = 1'b0;

  spi_master_rw dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .mode(mode), .cs_sel(cs_sel),
    .address(address), .wdata(wdata), .div(div),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .done_o(done_o), .busy(busy), .rdata(rdata), .SEN(SEN), .SCLK(SCLK), .SDATA(SDATA), .SDOUT(SDOUT));

  spi_master_rw #(.N_CS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start2), .rw(rw), .mode(mode), .cs_sel(cs2),
    .address(address), .wdata(wdata), .div(div),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .done_o(done2), .busy(busy2), .rdata(rdata2), .SEN(SEN2), .SCLK(SCLK2), .SDATA(SDATA2), .SDOUT(SDOUT));

  always #5 clk = ~clk;

  // Slave: captures MOSI on the CPHA capture edge, shifts MISO out on the other edge
  always @(negedge clk) begin
    low_now = SEN != 2'b11;
    if (done_o) done_cnt++;
    if (low_now && !prev_low) begin
      if (hi_cnt == 1) gap1++;
      edges = 0; ncap = 0; cap = '0; sen_cnt = 0; sen_frame = SEN;
      if (tb_cpha) mi = FRAME - 1;
      else begin SDOUT = miso_vec[FRAME-1]; mi = FRAME - 2; end
    end
    if (low_now) sen_cnt++;
    if (!low_now && prev_low) begin sen_len = sen_cnt; hi_cnt = 0; end
    if (!low_now) hi_cnt++;
    if (low_now && SCLK != prev_sclk) begin
      edges++;
      if ((edges % 2 == 1) != tb_cpha) begin cap = {cap[FRAME-2:0], SDATA}; ncap++; end
      else if (mi >= 0) begin SDOUT = miso_vec[mi]; mi--; end
    end
    prev_low = low_now;
    prev_sclk = SCLK;
  end

  task automatic check(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    int n, d0;
    @(negedge clk);
    rw = v.rw; mode = v.mode; cs_sel = v.cs; address = v.addr; wdata = v.wdata; div = v.div;
    miso_vec = {9'b0, v.resp}; tb_cpha = v.mode[0];
`ifdef SPI_LSB_FIRST_EN
    lsb_first = v.lsb;
`endif
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done_o && n < 3000) begin
      if (n == 20) begin
        check(tag, "busy_mid", busy, 1);
        start = 1'b1; cs_sel = ~v.cs; address = ~v.addr; wdata = ~v.wdata; div = ~v.div; mode = ~v.mode; rw = ~v.rw;
      end
      if (n == 21) begin
        start = 1'b0; cs_sel = v.cs; address = v.addr; wdata = v.wdata; div = v.div; mode = v.mode; rw = v.rw;
      end
      @(posedge clk); #1;
      n++;
    end
    check(tag, "latency", n + 1, v.sen_len + 1);
    check(tag, "rdata", rdata, v.rdata);
    @(posedge clk); #1;
    check(tag, "done_pulse", done_o, 0);
    check(tag, "sclk_idle", SCLK, v.mode[1]);
    check(tag, "sdata_idle", SDATA, 1);
    check(tag, "busy_end", busy, 0);
    check(tag, "mosi", cap, v.cap);
    check(tag, "nbits", ncap, FRAME);
    check(tag, "sen_len", sen_len, v.sen_len);
    check(tag, "sen_sel", sen_frame, v.sen);
    check(tag, "done_cnt", done_cnt - d0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int n, d0, nd, bad;
    tbl[0] = '{1'b0, 2'd0, 1'b1, 8'hA5, 16'h1234, 8'd2, 16'h0000, 1'b0, 25'h0A51234, 104, 2'b01, 16'h0000};
    tbl[1] = '{1'b1, 2'd3, 1'b0, 8'h3C, 16'h5555, 8'd3, 16'hBEEF, 1'b0, 25'h13C0000, 156, 2'b10, 16'hBEEF};
    tbl[2] = '{1'b0, 2'd1, 1'b0, 8'h81, 16'h8001, 8'd0, 16'h0000, 1'b0, 25'h0818001, 52, 2'b10, 16'hBEEF};
    tbl[3] = '{1'b0, 2'd2, 1'b1, 8'h7E, 16'h8001, 8'd0, 16'h0000, 1'b0, 25'h07E8001, 52, 2'b01, 16'hBEEF};
    tbl[4] = '{1'b1, 2'd1, 1'b1, 8'h42, 16'hFFFF, 8'd1, 16'h1357, 1'b0, 25'h1420000, 52, 2'b01, 16'h1357};
    tbl[5] = '{1'b1, 2'd0, 1'b0, 8'h99, 16'h1111, 8'd2, 16'hA0C3, 1'b0, 25'h1990000, 104, 2'b10, 16'hA0C3};
    tbl[6] = '{1'b1, 2'd2, 1'b1, 8'h10, 16'h0000, 8'd0, 16'h0F0F, 1'b0, 25'h1100000, 52, 2'b01, 16'h0F0F};
    tbl[7] = '{1'b0, 2'd3, 1'b0, 8'hFF, 16'hFFFF, 8'd5, 16'h0000, 1'b0, 25'h0FFFFFF, 260, 2'b10, 16'h0F0F};

    repeat (3) @(negedge clk);
    check("reset", "sen", SEN, 2'b11);
    check("reset", "sclk", SCLK, 0);
    check("reset", "sdata", SDATA, 1);
    check("reset", "done", done_o, 0);
    check("reset", "busy", busy, 0);
    check("reset", "rdata", rdata, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("v%0d", i));

    // reset in the middle of a frame
    @(negedge clk);
    rw = 1'b0; mode = 2'd0; cs_sel = 1'b0; address = 8'h5A; wdata = 16'hC3C3; div = 8'd2; tb_cpha = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst", "sen", SEN, 2'b11);
    check("midrst", "sclk", SCLK, 0);
    check("midrst", "sdata", SDATA, 1);
    check("midrst", "busy", busy, 0);
    check("midrst", "rdata", rdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst", "no_done", done_cnt - d0, 0);
    run(tbl[0], "after_rst");

    // start held high: three back-to-back frames
    @(negedge clk);
    rw = 1'b0; mode = 2'd0; cs_sel = 1'b0; address = 8'h11; wdata = 16'h2222; div = 8'd0; tb_cpha = 1'b0;
    @(negedge clk);
    gap1 = 0;
    d0 = done_cnt;
    nd = 0;
    start = 1'b1;
    for (int i = 0; i < 1000 && nd < 3; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    repeat (60) @(posedge clk);
    #1;
    check("b2b", "done_cnt", done_cnt - d0, 3);
    check("b2b", "gap_1cycle", gap1, 2);
    check("b2b", "busy", busy, 0);
    check("b2b", "sen", SEN, 2'b11);
    check("b2b", "mosi", cap, 25'h0112222);

    // out-of-range chip select on a three-select instance
    @(negedge clk);
    cs2 = 2'd3;
    start2 = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (SEN2 != 3'b111 || busy2 || done2) bad++;
    end
    check("badcs", "ignored", bad, 0);
    cs2 = 2'd2;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("cs2", "busy", busy2, 1);
    check("cs2", "sen", SEN2, 3'b011);
    n = 0;
    while (!done2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("cs2", "latency", n, 52);

`ifdef SPI_LSB_FIRST_EN
    begin
      vec_t lv[2];
      lv[0] = '{1'b0, 2'd0, 1'b0, 8'h01, 16'h0003, 8'd0, 16'h0000, 1'b1, 25'h080C000, 52, 2'b10, 16'h0000};
      lv[1] = '{1'b1, 2'd0, 1'b0, 8'h01, 16'h0000, 8'd0, 16'hBEEF, 1'b1, 25'h1800000, 52, 2'b10, 16'hF77D};
      run(lv[0], "lsb_w");
      run(lv[1], "lsb_r");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
